mydesign_mul_arbiter: RTL
=========================

Name: mydesign_mul_arbiter

Overview:
- Shares one mydesign_comb multiplier instance between N_REQ requesters.
- Each requester has its own valid/ready request port. Arbitration is round-robin.
- Each granted product goes into a single registered response slot, tagged with the requester ID. The slot uses a valid/ready handshake.
- Sits where mydesign_top sits today: it is the sequencing/sharing wrapper around the combinational multiplier.

Parameters:
- N_IN, 4, operand width per operand (unsigned).
- N_OUT, 8, result width; must equal 2*N_IN.
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), localparam, requester ID width.

Ports:
- clk_ci  in  1  single clock, rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester grant/accept; at most one bit high.
- req_operand_a_i  in  N_REQ*N_IN  flattened operand A; requester i at bits [i*N_IN +: N_IN].
- req_operand_b_i  in  N_REQ*N_IN  flattened operand B, same packing.
- rsp_valid_o  out  1  response slot holds a valid result.
- rsp_ready_i  in  1  downstream accepts the response.
- rsp_result_o  out  N_OUT  registered product.
- rsp_id_o  out  ID_W  index of the requester that produced rsp_result_o.

Behaviour:
- Clocking/reset:
  - One clock (clk_ci). Reset is synchronous and active-low (rst_ni), sampled on the rising clk_ci edge.
  - Reset values: rsp_valid_o=0, rsp_result_o=0, rsp_id_o=0, rr_ptr=0.
  - req_ready_o is forced to all-zero while rst_ni is low.
  - Reset mid-operation drops any held response with no handshake.
- Slot state (2 states):
  - EMPTY: rsp_valid_o=0.
  - FULL: rsp_valid_o=1.
  - slot_free = EMPTY | (FULL & rsp_ready_i).
- Arbitration (combinational):
  - Search req_valid_i starting at index rr_ptr, upward with wrap-around modulo N_REQ.
  - The first set bit is g.
  - req_ready_o = onehot(g) when slot_free and any req_valid_i is set; else 0.
- Request handshake: req_valid_i[g] & req_ready_o[g]. On the next edge:
  - rsp_result_o <= unsigned a_g*b_g (from the mydesign_comb instance, muxed operands).
  - rsp_id_o <= g; slot becomes FULL.
  - rr_ptr <= (g+1) mod N_REQ.
- Latency: 1 cycle from request handshake to rsp_valid_o.
- Throughput: 1 result/cycle when rsp_ready_i is held high. Accepting a new request in the same cycle the old response drains is required.
- Drain with no new grant: FULL & rsp_ready_i & no request -> EMPTY.
- Stall: FULL & ~rsp_ready_i.
  - req_ready_o=0.
  - rsp_result_o and rsp_id_o are held stable.
  - rr_ptr is unchanged.
- rr_ptr changes only on a request handshake. Idle cycles do not move it.
- Requester rule: once req_valid_i[i] is asserted, it holds it and its operands stable until req_ready_o[i]. The bench asserts this rule.
- Arithmetic: operands unsigned; the product is exact in N_OUT bits, with no truncation.
- The multiplier instance keeps its dont_touch attribute. Operand mux and output register stay outside it.
- No combinational path from rsp_ready_i to rsp_valid_o. The rsp_ready_i -> req_ready_o path is allowed.

Decomposition:
- Shared package mydesign_pkg holds:
  - default N_IN/N_OUT constants;
  - function rr_pick(valid, ptr) returning {found, index};
  - typedef req_id_t sized by ID_W.
- One natural sub-module: mydesign_rr_picker. It is the combinational round-robin search with wrap, parameterised on N_REQ, and is reusable by later arbiters.
- mydesign_comb is instantiated unchanged.

Test Plan:
- Reset: hold rst_ni=0 for 3 edges with all req_valid_i=1.
  - Required: req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_id_o=0.
  - Release: first grant is requester 0.
- Single request: req 2 valid with a=15, b=15, rsp_ready_i=1.
  - Required: req_ready_o=4'b0100 that cycle; next cycle rsp_valid_o=1, rsp_result_o=225, rsp_id_o=2.
- Round-robin fairness: all 4 requests valid continuously, rsp_ready_i=1, a=i+1, b=3.
  - Required: grants 0,1,2,3,0 on consecutive cycles; results 3,6,9,12,3; no bubbles.
- Backpressure: slot FULL with result 42, rsp_ready_i=0 for 5 cycles, other requests pending.
  - Required: req_ready_o=0; rsp_result_o stays 42; rr_ptr is unchanged.
  - Raise rsp_ready_i: the drain and the next grant happen in the same cycle.
- Wrap/skip: rr_ptr=3 with only req 1 valid.
  - Required: grant 1 (wrap past 3 and 0); rr_ptr then becomes 2.
- Sync reset mid-operation: slot FULL, then assert rst_ni=0 for one edge.
  - Required: rsp_valid_o=0 after that edge, no response emitted, rr_ptr=0.

Source files
------------

// File: rtl/mydesign_pkg.sv
// Shared types, default widths and the round-robin search helper
// used by the multiplier arbiter and its picker sub-module.
package mydesign_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 8;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = $clog2(N_REQ_DEF);
  localparam int RR_MAX    = 16;

  typedef logic [ID_W_DEF-1:0] req_id_t;

  // Returns {found, index}. Search starts at ptr and wraps mod n.
  // Vectors are sized for the largest legal requester count.
  function automatic logic [4:0] rr_pick(
    input logic [RR_MAX-1:0] valid,
    input logic [3:0]        ptr,
    input int                n
  );
    logic       found;
    logic [3:0] idx;
    int         j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (!found && valid[j[3:0]]) begin
          found = 1'b1;
          idx   = j[3:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mydesign_comb.sv
// Combinational unsigned multiplier shared by the arbiter.
// Ports: a_i, b_i operands (N_IN); p_o exact product (N_OUT).
module mydesign_comb #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8
) (
  input  logic [N_IN-1:0]  a_i,
  input  logic [N_IN-1:0]  b_i,
  output logic [N_OUT-1:0] p_o
);

  assign p_o = N_OUT'(a_i) * N_OUT'(b_i);

endmodule

// File: rtl/mydesign_rr_picker.sv
// Combinational round-robin search with wrap-around.
// Ports: valid_i requests, ptr_i start index; found_o, idx_o pick.
module mydesign_rr_picker
  import mydesign_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [RR_MAX-1:0] valid_w;
  logic [3:0]        ptr_w;
  logic [4:0]        pick_w;

  always_comb begin
    valid_w              = '0;
    valid_w[N_REQ-1:0]   = valid_i;
    ptr_w                = '0;
    ptr_w[ID_W-1:0]      = ptr_i;
    pick_w               = rr_pick(valid_w, ptr_w, N_REQ);
  end

  assign found_o = pick_w[4];
  assign idx_o   = ID_W'(pick_w[3:0]);

endmodule

// File: rtl/mydesign_mul_arbiter.sv
// Round-robin sharing of one multiplier between N_REQ requesters.
// Ports: clk_ci, rst_ni; req_valid_i/req_ready_o/req_operand_{a,b}_i
// per requester; rsp_valid_o/rsp_ready_i/rsp_result_o/rsp_id_o slot.
module mydesign_mul_arbiter
  import mydesign_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  parameter  int N_OUT = N_OUT_DEF,
  parameter  int N_REQ = N_REQ_DEF,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk_ci,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*N_IN-1:0] req_operand_a_i,
  input  logic [N_REQ*N_IN-1:0] req_operand_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [N_OUT-1:0]      rsp_result_o,
  output logic [ID_W-1:0]       rsp_id_o
);

  if (N_OUT != 2 * N_IN) begin : g_bad_width
    $error("N_OUT must equal 2*N_IN");
  end
  if (N_REQ < 2 || N_REQ > RR_MAX) begin : g_bad_nreq
    $error("N_REQ out of range 2..16");
  end

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  slot_e             slot_q;
  logic [N_OUT-1:0]  result_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;

  logic              found;
  logic [ID_W-1:0]   grant_idx;
  logic              slot_free;
  logic              grant_en;
  logic [N_IN-1:0]   a_sel;
  logic [N_IN-1:0]   b_sel;
  logic [N_OUT-1:0]  prod;

  mydesign_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (found),
    .idx_o   (grant_idx)
  );

  // A draining slot can take a new product in the same cycle.
  assign slot_free = (slot_q == SLOT_EMPTY) | rsp_ready_i;
  assign grant_en  = rst_ni & slot_free & found;

  always_comb begin
    req_ready_o = '0;
    if (grant_en) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign a_sel = req_operand_a_i[int'(grant_idx)*N_IN +: N_IN];
  assign b_sel = req_operand_b_i[int'(grant_idx)*N_IN +: N_IN];

  (* dont_touch = "true" *)
  mydesign_comb #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_comb (
    .a_i (a_sel),
    .b_i (b_sel),
    .p_o (prod)
  );

  assign rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ?
                    '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_ci) begin
    if (!rst_ni) begin
      slot_q   <= SLOT_EMPTY;
      result_q <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else if (grant_en) begin
      slot_q   <= SLOT_FULL;
      result_q <= prod;
      id_q     <= grant_idx;
      rr_ptr_q <= rr_ptr_d;
    end else if (slot_q == SLOT_FULL && rsp_ready_i) begin
      slot_q   <= SLOT_EMPTY;
    end
  end

  assign rsp_valid_o  = (slot_q == SLOT_FULL);
  assign rsp_result_o = result_q;
  assign rsp_id_o     = id_q;

endmodule
